lfsr_checker: RTL and testbench

Receive-side companion to the 9-bit platform LFSR generator. Consumes a stream of 9-bit LFSR words, self-synchronises to it by seeding a local predictor from the incoming data, and then flywheels the predictor to flag corrupted or skipped words. Sits between any LFSR consumer (platform spawner, debug tap) and the generator. Reports lock status, per-sample error pulses and saturating statistics counters.

---
 rtl/lfsr_checker_if.sv | 24 ++
 rtl/lfsr_checker.sv | 120 ++++++++++++
 tb/tb_lfsr_checker.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_checker_if.sv
// Sample stream and status bundle between an LFSR consumer and lfsr_checker.
// The master drives samples and the counter clear; the slave returns lock status and statistics.
interface lfsr_checker_if #(
  parameter int CNT_W = 16
);
  logic             sample_valid;
  logic [8:0]       sample;
  logic             clear_counts;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] sample_count;
  logic [8:0]       expected;

  modport master (
    output sample_valid, sample, clear_counts,
    input  locked, err_pulse, err_count, sample_count, expected
  );

  modport slave (
    input  sample_valid, sample, clear_counts,
    output locked, err_pulse, err_count, sample_count, expected
  );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 9-bit platform LFSR.
// It seeds a predictor from the incoming stream, then flywheels that predictor to flag bad or skipped words.
module lfsr_checker #(
  parameter int LOCK_MATCHES  = 4,
  parameter int UNLOCK_ERRORS = 3,
  parameter int CNT_W         = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  lfsr_checker_if.slave  bus
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [3:0] LOCK_M   = 4'(LOCK_MATCHES);
  localparam logic [3:0] UNLOCK_E = 4'(UNLOCK_ERRORS);

  state_t           state, state_n;
  logic [8:0]       expected_q, expected_n;
  logic [3:0]       match_cnt, match_n;
  logic [3:0]       miss_cnt, miss_n;
  logic             err_pulse_q, err_pulse_n;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_n;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_n;
  logic             hit;

  // The all-ones word would lock an XNOR LFSR, so its feedback is inverted to escape.
  function automatic logic [8:0] lfsr_next(input logic [8:0] x);
    logic fb;
    if (x == 9'h1FF) fb = x[3] ^ x[8];
    else             fb = ~(x[3] ^ x[8]);
    return {x[7:0], fb};
  endfunction

  assign hit = (bus.sample == expected_q);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= SEARCH;
      expected_q  <= 9'h000;
      match_cnt   <= 4'd0;
      miss_cnt    <= 4'd0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      smp_cnt_q   <= '0;
    end else begin
      state       <= state_n;
      expected_q  <= expected_n;
      match_cnt   <= match_n;
      miss_cnt    <= miss_n;
      err_pulse_q <= err_pulse_n;
      err_cnt_q   <= err_cnt_n;
      smp_cnt_q   <= smp_cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    if (bus.sample_valid) begin
      case (state)
        SEARCH:  state_n = VERIFY;
        VERIFY:  if (hit && (match_cnt + 4'd1 == LOCK_M)) state_n = LOCKED;
        LOCKED:  if (!hit && (miss_cnt + 4'd1 == UNLOCK_E)) state_n = SEARCH;
        default: state_n = SEARCH;
      endcase
    end
  end

  // Outside lock the predictor is reseeded from the data; in lock it only flywheels.
  always_comb begin
    expected_n  = expected_q;
    match_n     = match_cnt;
    miss_n      = miss_cnt;
    err_pulse_n = 1'b0;
    err_cnt_n   = err_cnt_q;
    smp_cnt_n   = smp_cnt_q;
    if (bus.sample_valid) begin
      case (state)
        SEARCH: begin
          expected_n = lfsr_next(bus.sample);
          match_n    = 4'd0;
        end
        VERIFY: begin
          expected_n = lfsr_next(bus.sample);
          if (hit) begin
            match_n = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == LOCK_M) miss_n = 4'd0;
          end else begin
            match_n = 4'd0;
          end
        end
        LOCKED: begin
          expected_n = lfsr_next(expected_q);
          if (smp_cnt_q != '1) smp_cnt_n = smp_cnt_q + 1'b1;
          if (hit) begin
            miss_n = 4'd0;
          end else begin
            err_pulse_n = 1'b1;
            miss_n      = miss_cnt + 4'd1;
            if (err_cnt_q != '1) err_cnt_n = err_cnt_q + 1'b1;
          end
        end
        default: begin
          expected_n = expected_q;
        end
      endcase
    end
    if (bus.clear_counts) begin
      err_cnt_n = '0;
      smp_cnt_n = '0;
    end
  end

  assign bus.locked       = (state == LOCKED);
  assign bus.err_pulse    = err_pulse_q;
  assign bus.err_count    = err_cnt_q;
  assign bus.sample_count = smp_cnt_q;
  assign bus.expected     = expected_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a behavioural model queues the expected outputs for each driven edge,
// and directed checks pin down the hand-derived values.
module tb_lfsr_checker;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  lfsr_checker_if #(.CNT_W(CW)) bus ();

  lfsr_checker #(.LOCK_MATCHES(4), .UNLOCK_ERRORS(3), .CNT_W(CW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic          locked;
    logic          pulse;
    logic [CW-1:0] errc;
    logic [CW-1:0] smpc;
    logic [8:0]    exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  int         m_state;
  logic [8:0] m_exp;
  int         m_mc, m_mis, m_err, m_cnt;
  logic       m_pulse;

  function automatic logic [8:0] succ(input logic [8:0] x);
    logic fb;
    fb = (x[3] == x[8]) && (x != 9'h1FF);
    return {x[7:0], fb};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic modelStep(input logic rst, input logic v, input logic [8:0] s, input logic clr);
    if (!rst) begin
      m_state = 0; m_exp = 9'h000; m_mc = 0; m_mis = 0;
      m_pulse = 1'b0; m_err = 0; m_cnt = 0;
    end else begin
      m_pulse = 1'b0;
      if (v) begin
        if (m_state == 0) begin
          m_exp = succ(s); m_mc = 0; m_state = 1;
        end else if (m_state == 1) begin
          if (s == m_exp) begin
            m_mc++;
            if (m_mc == 4) begin m_state = 2; m_mis = 0; end
          end else begin
            m_mc = 0;
          end
          m_exp = succ(s);
        end else begin
          if (m_cnt < CMAX) m_cnt++;
          if (s == m_exp) begin
            m_mis = 0;
          end else begin
            m_pulse = 1'b1;
            if (m_err < CMAX) m_err++;
            m_mis++;
            if (m_mis == 3) m_state = 0;
          end
          m_exp = succ(m_exp);
        end
      end
      if (clr) begin m_err = 0; m_cnt = 0; end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic [8:0] s, input logic clr);
    exp_t e;
    Reset            = rst;
    bus.sample_valid = v;
    bus.sample       = s;
    bus.clear_counts = clr;
    modelStep(rst, v, s, clr);
    e.locked = (m_state == 2);
    e.pulse  = m_pulse;
    e.errc   = CW'(m_err);
    e.smpc   = CW'(m_cnt);
    e.exp    = m_exp;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    checkOutput("sb_locked", 16'(bus.locked), 16'(e.locked));
    checkOutput("sb_err_pulse", 16'(bus.err_pulse), 16'(e.pulse));
    checkOutput("sb_err_count", 16'(bus.err_count), 16'(e.errc));
    checkOutput("sb_sample_count", 16'(bus.sample_count), 16'(e.smpc));
    checkOutput("sb_expected", 16'(bus.expected), 16'(e.exp));
  endtask

  task automatic feed(input logic [8:0] s);
    applyStimulus(1'b1, 1'b1, s, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 9'h000, 1'b0);
  endtask

  initial begin
    int r;
    logic [8:0] s;

    applyStimulus(1'b0, 1'b0, 9'h000, 1'b0);
    applyStimulus(1'b0, 1'b1, 9'h123, 1'b1);
    checkOutput("rst_locked", 16'(bus.locked), 16'h0);
    checkOutput("rst_expected", 16'(bus.expected), 16'h000);
    checkOutput("rst_err_count", 16'(bus.err_count), 16'h0);

    // Acquire lock from a clean stream.
    feed(9'h000); feed(9'h001); feed(9'h003); feed(9'h007);
    checkOutput("lock_not_yet", 16'(bus.locked), 16'h0);
    feed(9'h00F);
    checkOutput("lock_rise", 16'(bus.locked), 16'h1);
    checkOutput("lock_expected", 16'(bus.expected), 16'h01E);
    feed(9'h01E);
    checkOutput("lock_smp_count", 16'(bus.sample_count), 16'h1);
    checkOutput("lock_expected2", 16'(bus.expected), 16'h03C);

    idle(); idle(); idle();
    checkOutput("gap_keeps_lock", 16'(bus.locked), 16'h1);

    feed(9'h000);
    checkOutput("single_err_pulse", 16'(bus.err_pulse), 16'h1);
    checkOutput("single_err_count", 16'(bus.err_count), 16'h1);
    feed(9'h078);
    checkOutput("single_no_pulse", 16'(bus.err_pulse), 16'h0);
    checkOutput("single_still_lock", 16'(bus.locked), 16'h1);
    checkOutput("single_expected", 16'(bus.expected), 16'h0F0);

    // Three consecutive wrong words must drop lock.
    feed(m_exp ^ 9'h0A5); feed(m_exp ^ 9'h0A5);
    checkOutput("unlock_hold", 16'(bus.locked), 16'h1);
    feed(m_exp ^ 9'h0A5);
    checkOutput("unlock_pulse3", 16'(bus.err_pulse), 16'h1);
    checkOutput("unlock_fall", 16'(bus.locked), 16'h0);
    checkOutput("unlock_err_count", 16'(bus.err_count), 16'h4);
    feed(9'h1AA);
    checkOutput("unlock_reseed", 16'(bus.expected), 16'h155);

    feed(9'h000); feed(9'h001); feed(9'h1AA);
    checkOutput("verify_reseed", 16'(bus.expected), 16'h155);
    checkOutput("verify_no_lock", 16'(bus.locked), 16'h0);

    // The all-ones word must escape through the inverted feedback.
    applyStimulus(1'b0, 1'b0, 9'h000, 1'b0);
    feed(9'h1FF);
    checkOutput("escape_1ff", 16'(bus.expected), 16'h1FE);
    feed(9'h1FE);
    checkOutput("escape_1fe", 16'(bus.expected), 16'h1FD);
    checkOutput("escape_no_pulse", 16'(bus.err_pulse), 16'h0);
    feed(m_exp); feed(m_exp); feed(m_exp);
    checkOutput("escape_locked", 16'(bus.locked), 16'h1);

    for (int i = 0; i < 17; i++) feed(m_exp);
    checkOutput("smp_saturate", 16'(bus.sample_count), 16'(CMAX));

    for (int i = 0; i < 16; i++) begin
      feed(m_exp ^ 9'h011);
      feed(m_exp);
      if (i == 4) checkOutput("err_count5", 16'(bus.err_count), 16'h5);
    end
    checkOutput("err_saturate", 16'(bus.err_count), 16'(CMAX));

    applyStimulus(1'b1, 1'b1, m_exp ^ 9'h001, 1'b1);
    checkOutput("clear_err", 16'(bus.err_count), 16'h0);
    checkOutput("clear_smp", 16'(bus.sample_count), 16'h0);
    checkOutput("clear_keeps_lock", 16'(bus.locked), 16'h1);

    applyStimulus(1'b0, 1'b1, m_exp, 1'b0);
    checkOutput("reset_locked", 16'(bus.locked), 16'h0);
    checkOutput("reset_expected", 16'(bus.expected), 16'h000);
    checkOutput("reset_pulse", 16'(bus.err_pulse), 16'h0);

    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 11);
      s = (r < 9) ? m_exp : 9'($urandom_range(0, 511));
      applyStimulus(1'b1, (r != 0), s, (r == 11));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
